// File: rtl/car_lane_ctrl_pkg.sv
// +----------------------------------------------------------------------+
// | car_lane_ctrl_pkg : shared lane geometry, lane codes and FSM states   |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

package car_lane_ctrl_pkg;

    localparam int unsigned c_XW = 10;

    localparam logic [c_XW-1:0] c_LANE_L_X = 10'd197;
    localparam logic [c_XW-1:0] c_LANE_C_X = 10'd279;
    localparam logic [c_XW-1:0] c_LANE_R_X = 10'd361;
    localparam logic [c_XW-1:0] c_CAR_Y    = 10'd357;
    localparam logic [c_XW-1:0] c_STEP_PX  = 10'd4;

    localparam logic [1:0] c_LANE_L = 2'd0;
    localparam logic [1:0] c_LANE_C = 2'd1;
    localparam logic [1:0] c_LANE_R = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SLIDE_L = 2'd1,
        ST_SLIDE_R = 2'd2
    } lane_state_t;

endpackage

`default_nettype wire

// File: rtl/car_lane_ctrl_button_debounce.sv
// +----------------------------------------------------------------------+
// | car_lane_ctrl_button_debounce : 2-FF sync, stability counter and     |
// | one-shot pulse on the debounced rising edge                          |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module car_lane_ctrl_button_debounce #(
    parameter int unsigned DB_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn,
    output logic o_pulse
);

    localparam int unsigned    c_CW      = $clog2(DB_CYCLES + 1);
    localparam logic [c_CW-1:0] c_CNT_MAX = c_CW'(DB_CYCLES - 1);

    logic [1:0]      r_sync;
    logic            r_db;
    logic            r_pulse;
    logic [c_CW-1:0] r_cnt;
    logic            w_s;

    assign w_s     = r_sync[1];
    assign o_pulse = r_pulse;

    // Counter only runs while the synchronised level disagrees with the
    // accepted level; any return to agreement reloads it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync  <= 2'b00;
            r_db    <= 1'b0;
            r_pulse <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync  <= {r_sync[0], i_btn};
            r_pulse <= 1'b0;
            if (w_s == r_db) begin
                r_cnt <= '0;
            end else if (r_cnt == c_CNT_MAX) begin
                r_db    <= w_s;
                r_pulse <= w_s;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/car_lane_ctrl.sv
// +----------------------------------------------------------------------+
// | car_lane_ctrl : debounced lane requests drive a 3-lane slide FSM     |
// | that updates the car sprite x origin only on frame_tick              |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module car_lane_ctrl
    import car_lane_ctrl_pkg::*;
#(
    parameter logic [9:0]  LANE_L_X  = c_LANE_L_X,
    parameter logic [9:0]  LANE_C_X  = c_LANE_C_X,
    parameter logic [9:0]  LANE_R_X  = c_LANE_R_X,
    parameter logic [9:0]  CAR_Y     = c_CAR_Y,
    parameter logic [9:0]  STEP_PX   = c_STEP_PX,
    parameter int unsigned DB_CYCLES = 250000
) (
    input  logic       vga_clk,
    input  logic       reset,
    input  logic       left,
    input  logic       right,
    input  logic       frame_tick,
    output logic [9:0] offset_car_x,
    output logic [9:0] offset_car_y,
    output logic [1:0] lane,
    output logic       moving
);

    lane_state_t r_state, w_state_nxt;
    logic [1:0]  r_lane, w_lane_nxt;
    logic [1:0]  r_target, w_target_nxt;
    logic [9:0]  r_x, w_x_nxt;
    logic        r_pend_v, w_pend_v_nxt;
    logic        r_pend_r, w_pend_r_nxt;

    logic        w_pulse_l, w_pulse_r;
    logic        w_req_l, w_req_r, w_any_req;
    logic        w_want_l, w_want_r;
    logic [9:0]  w_target_x, w_dist;

    function automatic logic [9:0] f_lane_x(input logic [1:0] i_l);
        case (i_l)
            c_LANE_L: f_lane_x = LANE_L_X;
            c_LANE_R: f_lane_x = LANE_R_X;
            default:  f_lane_x = LANE_C_X;
        endcase
    endfunction

    car_lane_ctrl_button_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_left (
        .clk     (vga_clk),
        .rst_n   (reset),
        .i_btn   (left),
        .o_pulse (w_pulse_l)
    );

    car_lane_ctrl_button_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_right (
        .clk     (vga_clk),
        .rst_n   (reset),
        .i_btn   (right),
        .o_pulse (w_pulse_r)
    );

    // Simultaneous requests cancel each other.
    assign w_req_l   = w_pulse_l & ~w_pulse_r;
    assign w_req_r   = w_pulse_r & ~w_pulse_l;
    assign w_any_req = w_req_l | w_req_r;

    // A fresh request wins over the stored one.
    assign w_want_l = w_any_req ? w_req_l : (r_pend_v & ~r_pend_r);
    assign w_want_r = w_any_req ? w_req_r : (r_pend_v &  r_pend_r);

    assign w_target_x = f_lane_x(r_target);
    assign w_dist     = (w_target_x >= r_x) ? (w_target_x - r_x) : (r_x - w_target_x);

    always_comb begin
        w_state_nxt  = r_state;
        w_lane_nxt   = r_lane;
        w_target_nxt = r_target;
        w_x_nxt      = r_x;
        w_pend_v_nxt = r_pend_v;
        w_pend_r_nxt = r_pend_r;
        case (r_state)
            ST_IDLE: begin
                w_pend_v_nxt = 1'b0;
                if (w_want_l && (r_lane != c_LANE_L)) begin
                    w_state_nxt  = ST_SLIDE_L;
                    w_target_nxt = r_lane - 2'd1;
                end else if (w_want_r && (r_lane != c_LANE_R)) begin
                    w_state_nxt  = ST_SLIDE_R;
                    w_target_nxt = r_lane + 2'd1;
                end
            end
            ST_SLIDE_L, ST_SLIDE_R: begin
                if (w_any_req) begin
                    w_pend_v_nxt = 1'b1;
                    w_pend_r_nxt = w_req_r;
                end
                if (frame_tick) begin
                    if (w_dist <= STEP_PX) begin
                        w_x_nxt     = w_target_x;
                        w_lane_nxt  = r_target;
                        w_state_nxt = ST_IDLE;
                    end else if (r_state == ST_SLIDE_R) begin
                        w_x_nxt = r_x + STEP_PX;
                    end else begin
                        w_x_nxt = r_x - STEP_PX;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge vga_clk or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_lane   <= c_LANE_C;
            r_target <= c_LANE_C;
            r_x      <= LANE_C_X;
            r_pend_v <= 1'b0;
            r_pend_r <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_lane   <= w_lane_nxt;
            r_target <= w_target_nxt;
            r_x      <= w_x_nxt;
            r_pend_v <= w_pend_v_nxt;
            r_pend_r <= w_pend_r_nxt;
        end
    end

    assign offset_car_x = r_x;
    assign offset_car_y = CAR_Y;
    assign lane         = r_lane;
    assign moving       = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_car_lane_ctrl.sv
// +----------------------------------------------------------------------+
// | tb_car_lane_ctrl : directed self-checking bench for car_lane_ctrl    |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_car_lane_ctrl;

    logic       clk;
    logic       reset;
    logic       left;
    logic       right;
    logic       frame_tick;
    logic [9:0] offset_car_x;
    logic [9:0] offset_car_y;
    logic [1:0] lane;
    logic       moving;

    int n_total = 0;
    int n_bad   = 0;

    car_lane_ctrl #(.DB_CYCLES(4)) u_dut (
        .vga_clk      (clk),
        .reset        (reset),
        .left         (left),
        .right        (right),
        .frame_tick   (frame_tick),
        .offset_car_x (offset_car_x),
        .offset_car_y (offset_car_y),
        .lane         (lane),
        .moving       (moving)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Hold the selected buttons 10 cycles, release, then let the release debounce.
    task automatic press(input logic l, input logic r);
        left  = l;
        right = r;
        step(10);
        left  = 1'b0;
        right = 1'b0;
        step(8);
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        step(1);
        frame_tick = 1'b0;
    endtask

    // 82 px lane-to-lane slide: ticks 1..20 move 4 px, tick 21 snaps.
    task automatic ticks(input string tag, input int from, input int to, input int k0, input int k1);
        int exp;
        for (int k = k0; k <= k1; k++) begin
            tick();
            if (k >= 21)       exp = to;
            else if (to > from) exp = from + 4 * k;
            else               exp = from - 4 * k;
            chk(tag, offset_car_x, exp);
            if (k < 21) chk({tag, "_mov"}, moving, 1);
            step(2);
        end
    endtask

    initial begin
        reset      = 1'b0;
        left       = 1'b0;
        right      = 1'b0;
        frame_tick = 1'b0;

        // 1: reset values, and held after release
        #50;
        chk("rst_x", offset_car_x, 279);
        chk("rst_y", offset_car_y, 357);
        chk("rst_lane", lane, 1);
        chk("rst_mov", moving, 0);
        @(negedge clk);
        reset = 1'b1;
        step(5);
        chk("post_rst_x", offset_car_x, 279);
        chk("post_rst_mov", moving, 0);

        // 2: C -> R
        right = 1'b1;
        step(10);
        chk("r_start_mov", moving, 1);
        chk("r_start_x", offset_car_x, 279);
        right = 1'b0;
        step(8);
        chk("r_no_tick_x", offset_car_x, 279);
        ticks("c2r_x", 279, 361, 1, 20);
        chk("c2r_lane_mid", lane, 1);
        ticks("c2r_x", 279, 361, 21, 21);
        chk("c2r_lane", lane, 2);
        chk("c2r_mov", moving, 0);

        // 3: edge request ignored, then R -> C
        press(1'b0, 1'b1);
        chk("edge_mov", moving, 0);
        chk("edge_x", offset_car_x, 361);
        chk("edge_lane", lane, 2);
        press(1'b1, 1'b0);
        chk("r2c_start", moving, 1);
        ticks("r2c_x", 361, 279, 1, 21);
        chk("r2c_lane", lane, 1);
        chk("r2c_mov", moving, 0);

        // 4: simultaneous press dropped; short glitch ignored
        press(1'b1, 1'b1);
        chk("both_mov", moving, 0);
        chk("both_x", offset_car_x, 279);
        left = 1'b1;
        step(3);
        left = 1'b0;
        step(10);
        chk("glitch_mov", moving, 0);
        chk("glitch_lane", lane, 1);

        // 5: go to L, then L -> C with a pending right captured mid-slide
        press(1'b1, 1'b0);
        ticks("c2l_x", 279, 197, 1, 21);
        chk("c2l_lane", lane, 0);
        press(1'b0, 1'b1);
        ticks("l2c_x", 197, 279, 1, 5);
        press(1'b0, 1'b1);
        chk("pend_mov", moving, 1);
        chk("pend_lane", lane, 0);
        chk("pend_x", offset_car_x, 217);
        ticks("l2c_x", 197, 279, 6, 20);
        tick();
        chk("arrive_x", offset_car_x, 279);
        chk("arrive_lane", lane, 1);
        chk("arrive_mov", moving, 0);
        step(1);
        chk("pend_go_mov", moving, 1);
        ticks("c2r2_x", 279, 361, 1, 21);
        chk("c2r2_lane", lane, 2);

        // 6: frozen without ticks, async reset mid-slide
        press(1'b1, 1'b0);
        ticks("frz_x", 361, 279, 1, 3);
        step(20);
        chk("frozen_x", offset_car_x, 349);
        chk("frozen_mov", moving, 1);
        @(posedge clk);
        #7;
        reset = 1'b0;
        #1;
        chk("arst_x", offset_car_x, 279);
        chk("arst_lane", lane, 1);
        chk("arst_mov", moving, 0);
        @(negedge clk);
        reset = 1'b1;
        step(4);
        chk("arst_hold_x", offset_car_x, 279);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
